seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 1, meaning: consecutive cycles an anode/cathode pair must hold unchanged before it is captured (range 1-15).
REQ-002 fast_clk  input  1  display scan clock, all logic on rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 anode  input  4  active-low digit select: 0111=min tens, 1011=min ones, 1101=sec tens, 1110=sec ones.
REQ-005 cathode  input  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-006 min_tens, min_ones, sec_tens, sec_ones  output  4 each  last accepted frame, BCD.
REQ-007 frame_valid  output  1  one-cycle pulse when a new frame is accepted.
REQ-008 seq_err, pattern_err, range_err  output  1 each  one-cycle error pulses.
REQ-009 locked  output  1  high while the FSM is synchronised to scan order.

Function
REQ-010 anode and cathode SHALL be registered once on entry; all decisions use registered values.
REQ-011 A stability counter SHALL count consecutive cycles with unchanged registered {anode,cathode}, saturating at SETTLE; a pair is captured once, when the count reaches SETTLE, and not again until the pair changes.
REQ-012 anode 1111 (blank) SHALL be ignored: no capture, no error, FSM state unchanged.
REQ-013 anode with more than one low bit SHALL pulse seq_err and return the FSM to WAIT_MT.
REQ-014 FSM states WAIT_MT, GOT_MT, GOT_MO, GOT_ST; WAIT_MT->GOT_MT on MT capture; GOT_MT->GOT_MO on MO; GOT_MO->GOT_ST on ST; GOT_ST->WAIT_MT on SO capture (frame end).
REQ-015 A capture out of order SHALL pulse seq_err and discard the partial frame; if the out-of-order digit is MT it SHALL be taken as a new frame start (go to GOT_MT), otherwise go to WAIT_MT.
REQ-016 Each captured cathode SHALL be decoded to 0-9 via the standard encodings; a non-matching pattern marks the frame bad.
REQ-017 At frame end, a good frame SHALL update all four digit outputs simultaneously and pulse frame_valid the next cycle; a bad frame SHALL pulse pattern_err and leave outputs unchanged.
REQ-018 Latency: frame_valid high exactly SETTLE+1 cycles after the sec-ones pair is first sampled into the input register.
REQ-019 locked SHALL set on any frame_valid and clear on seq_err or pattern_err.
REQ-020 Identical consecutive frames SHALL each pulse frame_valid.

Reset
REQ-021 RESET SHALL clear input registers, counter, digit outputs to 0, all pulses and locked to 0, FSM to WAIT_MT; assertion mid-frame discards the partial frame with no error pulse.

Configuration
REQ-022 With SEG_SCAN_RANGE_CHECK_EN defined, a frame with min_tens>5 or sec_tens>5 SHALL pulse range_err instead of frame_valid and leave outputs unchanged; without it any 0-9 digits are accepted and range_err is tied 0.

Structure
REQ-023 Package seg_scan_pkg SHALL hold the ten cathode encodings (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000), the four anode constants and the FSM state type.
REQ-024 Combinational sub-module seg_decode (cathode -> digit, hit) SHALL be instantiated once on the captured cathode.

Verification
REQ-025 SETTLE=1, scan 12:34 continuously (MT,MO,ST,SO one cycle each) -> digits 1,2,3,4, frame_valid every 4 cycles, first pulse 2 cycles after SO sampled, locked=1.
REQ-026 Scan MT, ST (skip MO) -> seq_err one pulse, no frame_valid, outputs hold; next full 05:09 scan -> outputs 0,5,0,9.
REQ-027 Cathode 1111111 on ST during 12:34 scan -> pattern_err one pulse, outputs stay at previous frame, locked=0.
REQ-028 SETTLE=3, each digit held 3 cycles with 1111 blanks between digits -> one frame_valid per scan, no errors.
REQ-029 RESET asserted after MO capture, released, full 00:00 scan -> outputs 0000, no error pulses.
REQ-030 Scan 75:00 -> with SEG_SCAN_RANGE_CHECK_EN range_err pulse and outputs hold; without it frame_valid and digits 7,5,0,0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared constants for the multiplexed 7-segment scan decoder:
//   - active-low cathode encodings for digits 0-9, bit order {g,f,e,d,c,b,a}
//   - active-low anode codes for the four digit positions and the blank code
//   - scan-order FSM state type and helpers for anode classification
// Optional feature macro used by the top level: SEG_SCAN_RANGE_CHECK_EN
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Indexed by digit value so the decoder can build its match vector in a loop.
    localparam logic [9:0][6:0] SEG_CODES = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    localparam logic [3:0] AN_MT    = 4'b0111;
    localparam logic [3:0] AN_MO    = 4'b1011;
    localparam logic [3:0] AN_ST    = 4'b1101;
    localparam logic [3:0] AN_SO    = 4'b1110;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    typedef enum logic [1:0] {
        WAIT_MT,
        GOT_MT,
        GOT_MO,
        GOT_ST
    } scan_state_t;

    // Exactly one digit selected.
    function automatic logic is_digit_anode(input logic [3:0] a);
        return (a == AN_MT) || (a == AN_MO) || (a == AN_ST) || (a == AN_SO);
    endfunction

    // The digit that must be captured next to stay in scan order.
    function automatic logic [3:0] expected_anode(input scan_state_t s);
        case (s)
            WAIT_MT: return AN_MT;
            GOT_MT:  return AN_MO;
            GOT_MO:  return AN_ST;
            default: return AN_SO;
        endcase
    endfunction

endpackage

// File: rtl/seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Combinational decode of an active-low 7-segment cathode pattern to BCD.
// Ports:
//   cathode [6:0] in  : active-low segments {g,f,e,d,c,b,a}
//   digit   [3:0] out : decoded value 0-9 (0 when no pattern matches)
//   hit           out : 1 when cathode matches one of the ten encodings
// -----------------------------------------------------------------------------
module seg_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] cathode,
    output logic [3:0] digit,
    output logic       hit
);

    logic [9:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_match
            assign match[gi] = (cathode == SEG_CODES[gi]);
        end
    endgenerate

    // Encodings are distinct, so at most one match bit is set.
    always_comb begin
        digit = 4'd0;
        hit   = |match;
        for (int i = 0; i < 10; i++) begin
            if (match[i]) digit = 4'(i);
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Recovers an MM:SS time value by snooping a multiplexed 4-digit 7-segment
// display scan. Each anode/cathode pair must be stable for SETTLE cycles before
// it is captured; captures must arrive in order MT, MO, ST, SO to form a frame.
// Ports:
//   fast_clk            in  : scan clock, rising edge
//   RESET               in  : asynchronous active-high reset
//   anode[3:0]          in  : active-low digit select (1111 = blank)
//   cathode[6:0]        in  : active-low segments {g,f,e,d,c,b,a}
//   min_tens..sec_ones  out : last accepted frame, BCD
//   frame_valid         out : one-cycle pulse per accepted frame
//   seq_err             out : one-cycle pulse on scan order violation
//   pattern_err         out : one-cycle pulse on a frame with an undecodable digit
//   range_err           out : one-cycle pulse on a tens digit above 5
//   locked              out : high while synchronised to the scan order
// Optional: define SEG_SCAN_RANGE_CHECK_EN to reject frames whose min_tens or
// sec_tens exceed 5; otherwise range_err is tied low.
// -----------------------------------------------------------------------------
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE = 1
)
(
    input  logic       fast_clk,
    input  logic       RESET,
    input  logic [3:0] anode,
    input  logic [6:0] cathode,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       frame_valid,
    output logic       seq_err,
    output logic       pattern_err,
    output logic       range_err,
    output logic       locked
);

    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    logic [3:0]  anode_reg;
    logic [6:0]  cathode_reg;
    logic [3:0]  cnt_reg, cnt_next;
    logic        capture_reg, capture_next;
    logic        changed;

    scan_state_t state_reg;
    logic [3:0]  mt_reg, mo_reg, st_reg;
    logic        bad_reg;
    logic        pend_fv_reg, pend_pat_reg;

    logic [3:0]  dec_digit;
    logic        dec_hit;
    logic        is_blank;
    logic        seq_hit;

    // ---------------- input register and stability counter ----------------
    assign changed = {anode, cathode} != {anode_reg, cathode_reg};

    always_comb begin
        if (changed)                 cnt_next = 4'd1;
        else if (cnt_reg >= SETTLE_W) cnt_next = SETTLE_W;
        else                         cnt_next = cnt_reg + 4'd1;
        // Fire only on the cycle the count first reaches SETTLE for this pair.
        capture_next = (cnt_next == SETTLE_W) && (changed || (cnt_reg != SETTLE_W));
    end

    always_ff @(posedge fast_clk or posedge RESET) begin
        if (RESET) begin
            anode_reg   <= 4'd0;
            cathode_reg <= 7'd0;
            cnt_reg     <= 4'd0;
            capture_reg <= 1'b0;
        end else begin
            anode_reg   <= anode;
            cathode_reg <= cathode;
            cnt_reg     <= cnt_next;
            capture_reg <= capture_next;
        end
    end

    // capture_reg is aligned with the registered pair it refers to.
    seg_decode u_decode (
        .cathode (cathode_reg),
        .digit   (dec_digit),
        .hit     (dec_hit)
    );

    assign is_blank = (anode_reg == AN_BLANK);
    assign seq_hit  = capture_reg && !is_blank &&
                      (!is_digit_anode(anode_reg) || (anode_reg != expected_anode(state_reg)));

`ifdef SEG_SCAN_RANGE_CHECK_EN
    logic range_bad;
    logic pend_rng_reg;
    assign range_bad = (mt_reg > 4'd5) || (st_reg > 4'd5);
`else
    assign range_err = 1'b0;
`endif

    // ---------------- scan-order FSM and registered outputs ----------------
    always_ff @(posedge fast_clk or posedge RESET) begin
        if (RESET) begin
            state_reg    <= WAIT_MT;
            mt_reg       <= 4'd0;
            mo_reg       <= 4'd0;
            st_reg       <= 4'd0;
            bad_reg      <= 1'b0;
            pend_fv_reg  <= 1'b0;
            pend_pat_reg <= 1'b0;
            min_tens     <= 4'd0;
            min_ones     <= 4'd0;
            sec_tens     <= 4'd0;
            sec_ones     <= 4'd0;
            frame_valid  <= 1'b0;
            seq_err      <= 1'b0;
            pattern_err  <= 1'b0;
            locked       <= 1'b0;
`ifdef SEG_SCAN_RANGE_CHECK_EN
            pend_rng_reg <= 1'b0;
            range_err    <= 1'b0;
`endif
        end else begin
            // Frame verdicts are decided at SO capture and reported one cycle later.
            pend_fv_reg  <= 1'b0;
            pend_pat_reg <= 1'b0;
            frame_valid  <= pend_fv_reg;
            pattern_err  <= pend_pat_reg;
            seq_err      <= seq_hit;
`ifdef SEG_SCAN_RANGE_CHECK_EN
            pend_rng_reg <= 1'b0;
            range_err    <= pend_rng_reg;
`endif

            if (seq_hit || pend_pat_reg) locked <= 1'b0;
            else if (pend_fv_reg)        locked <= 1'b1;

            if (capture_reg && !is_blank) begin
                if (seq_hit) begin
                    // Partial frame is dropped; an early MT restarts a frame.
                    if (anode_reg == AN_MT) begin
                        state_reg <= GOT_MT;
                        mt_reg    <= dec_digit;
                        bad_reg   <= !dec_hit;
                    end else begin
                        state_reg <= WAIT_MT;
                    end
                end else begin
                    case (state_reg)
                        WAIT_MT: begin
                            state_reg <= GOT_MT;
                            mt_reg    <= dec_digit;
                            bad_reg   <= !dec_hit;
                        end
                        GOT_MT: begin
                            state_reg <= GOT_MO;
                            mo_reg    <= dec_digit;
                            bad_reg   <= bad_reg | !dec_hit;
                        end
                        GOT_MO: begin
                            state_reg <= GOT_ST;
                            st_reg    <= dec_digit;
                            bad_reg   <= bad_reg | !dec_hit;
                        end
                        default: begin
                            state_reg <= WAIT_MT;
                            if (bad_reg || !dec_hit) begin
                                pend_pat_reg <= 1'b1;
                            end
`ifdef SEG_SCAN_RANGE_CHECK_EN
                            else if (range_bad) begin
                                pend_rng_reg <= 1'b1;
                            end
`endif
                            else begin
                                min_tens    <= mt_reg;
                                min_ones    <= mo_reg;
                                sec_tens    <= st_reg;
                                sec_ones    <= dec_digit;
                                pend_fv_reg <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Two instances (SETTLE=1 and SETTLE=3) share one stimulus stream. Expected
// output pulses are queued with their cycle of arrival and the displayed
// digits, and popped as the DUTs pulse.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int EV_FV  = 0;
    localparam int EV_SEQ = 1;
    localparam int EV_PAT = 2;
    localparam int EV_RNG = 3;

    localparam logic [3:0] A_MT = 4'b0111;
    localparam logic [3:0] A_MO = 4'b1011;
    localparam logic [3:0] A_ST = 4'b1101;
    localparam logic [3:0] A_SO = 4'b1110;
    localparam logic [3:0] A_BL = 4'b1111;

    logic       fast_clk = 1'b0;
    logic       RESET;
    logic [3:0] anode;
    logic [6:0] cathode;

    logic [3:0] mt_a, mo_a, st_a, so_a, mt_b, mo_b, st_b, so_b;
    logic       fv_a, seq_a, pat_a, rng_a, lk_a;
    logic       fv_b, seq_b, pat_b, rng_b, lk_b;
    logic [15:0] digs_a, digs_b;

    assign digs_a = {mt_a, mo_a, st_a, so_a};
    assign digs_b = {mt_b, mo_b, st_b, so_b};

    always #5 fast_clk = ~fast_clk;

    seg_scan_decoder #(.SETTLE(1)) dut_a (
        .fast_clk(fast_clk), .RESET(RESET), .anode(anode), .cathode(cathode),
        .min_tens(mt_a), .min_ones(mo_a), .sec_tens(st_a), .sec_ones(so_a),
        .frame_valid(fv_a), .seq_err(seq_a), .pattern_err(pat_a),
        .range_err(rng_a), .locked(lk_a)
    );

    seg_scan_decoder #(.SETTLE(3)) dut_b (
        .fast_clk(fast_clk), .RESET(RESET), .anode(anode), .cathode(cathode),
        .min_tens(mt_b), .min_ones(mo_b), .sec_tens(st_b), .sec_ones(so_b),
        .frame_valid(fv_b), .seq_err(seq_b), .pattern_err(pat_b),
        .range_err(rng_b), .locked(lk_b)
    );

    int cyc = 0;
    always @(posedge fast_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [7:0]  kind;
        logic [15:0] digs;
        logic [31:0] at;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Capture at sample edge k: seq_err visible at k+SETTLE, frame verdicts at k+SETTLE+1.
    task automatic exp_at(input int d, input int kind, input logic [15:0] digs, input int k);
        ev_t e;
        int  s;
        s = (d == 0) ? 1 : 3;
        e.kind = 8'(kind);
        e.digs = digs;
        e.at   = 32'(k + s + ((kind == EV_SEQ) ? 0 : 1));
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic q_pop(input int d, output ev_t e);
        if (d == 0) e = q_a.pop_front(); else e = q_b.pop_front();
    endtask

    task automatic q_peek(input int d, output ev_t e);
        if (d == 0) e = q_a[0]; else e = q_b[0];
    endtask

    task automatic mon(input int d, input logic [3:0] pulses, input logic [15:0] digs);
        ev_t e;
        while (q_size(d) > 0) begin
            q_peek(d, e);
            if (int'(e.at) >= cyc) break;
            q_pop(d, e);
            check_eq($sformatf("dut%0d_missing_kind%0d_cycle", d, e.kind), cyc, e.at);
        end
        for (int k = 0; k < 4; k++) begin
            if (pulses[k]) begin
                if (q_size(d) == 0) begin
                    check_eq($sformatf("dut%0d_unexpected_pulse_kind", d), k, 99);
                end else begin
                    q_pop(d, e);
                    $display("dut%0d cycle %0d pulse kind %0d digits %04h", d, cyc, k, digs);
                    check_eq($sformatf("dut%0d_kind", d), k, e.kind);
                    check_eq($sformatf("dut%0d_cycle_kind%0d", d, k), cyc, e.at);
                    check_eq($sformatf("dut%0d_digits_kind%0d", d, k), digs, e.digs);
                end
            end
        end
    endtask

    always @(negedge fast_clk) begin
        mon(0, {rng_a, pat_a, seq_a, fv_a}, digs_a);
        mon(1, {rng_b, pat_b, seq_b, fv_b}, digs_b);
    end

    task automatic drive(input logic [3:0] a, input logic [6:0] c, input int n);
        anode   = a;
        cathode = c;
        repeat (n) begin
            @(posedge fast_clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drive(A_BL, 7'h7F, n);
    endtask

    // SO is sampled at (start + 3*(hold+gap)).
    task automatic scan(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                        input logic [6:0] c3, input int hold, input int gap);
        drive(A_MT, c0, hold);
        if (gap > 0) idle(gap);
        drive(A_MO, c1, hold);
        if (gap > 0) idle(gap);
        drive(A_ST, c2, hold);
        if (gap > 0) idle(gap);
        drive(A_SO, c3, hold);
    endtask

    logic [15:0] shown_a, shown_b;
    int b;

    initial begin
        RESET   = 1'b1;
        anode   = A_BL;
        cathode = 7'h7F;
        shown_a = 16'h0000;
        shown_b = 16'h0000;
        repeat (3) @(posedge fast_clk);
        #1;
        check_eq("reset_digits_a", digs_a, 16'h0000);
        check_eq("reset_digits_b", digs_b, 16'h0000);
        check_eq("reset_pulses_a", {fv_a, seq_a, pat_a, rng_a, lk_a}, 5'b0);
        check_eq("reset_pulses_b", {fv_b, seq_b, pat_b, rng_b, lk_b}, 5'b0);
        RESET = 1'b0;
        idle(4);

        // Continuous 12:34 scan, one cycle per digit: only SETTLE=1 captures.
        for (int r = 0; r < 3; r++) begin
            b = cyc + 1;
            exp_at(0, EV_FV, 16'h1234, b + 3);
            scan(seg(1), seg(2), seg(3), seg(4), 1, 0);
        end
        shown_a = 16'h1234;
        idle(6);
        check_eq("locked_a_after_1234", lk_a, 1'b1);
        check_eq("digits_a_1234", digs_a, 16'h1234);
        check_eq("locked_b_no_capture", lk_b, 1'b0);

        // MT then ST: order violation, then a clean 05:09 frame.
        b = cyc + 1;
        exp_at(0, EV_SEQ, shown_a, b + 1);
        drive(A_MT, seg(1), 1);
        drive(A_ST, seg(3), 1);
        b = cyc + 1;
        exp_at(0, EV_FV, 16'h0509, b + 3);
        scan(seg(0), seg(5), seg(0), seg(9), 1, 0);
        shown_a = 16'h0509;
        idle(6);
        check_eq("digits_a_0509", digs_a, 16'h0509);

        // Blank ST pattern: frame rejected, display holds, lock drops.
        b = cyc + 1;
        exp_at(0, EV_PAT, shown_a, b + 3);
        scan(seg(1), seg(2), 7'h7F, seg(4), 1, 0);
        idle(6);
        check_eq("locked_a_after_pattern", lk_a, 1'b0);
        check_eq("digits_a_hold_pattern", digs_a, 16'h0509);

        // Digits held 3 cycles with blanks between: both instances capture.
        for (int r = 0; r < 2; r++) begin
            b = cyc + 1;
            exp_at(0, EV_FV, 16'h2345, b + 15);
            exp_at(1, EV_FV, 16'h2345, b + 15);
            scan(seg(2), seg(3), seg(4), seg(5), 3, 2);
        end
        shown_a = 16'h2345;
        shown_b = 16'h2345;
        idle(8);
        check_eq("locked_a_2345", lk_a, 1'b1);
        check_eq("locked_b_2345", lk_b, 1'b1);

        // Reset after MO capture discards the partial frame silently.
        drive(A_MT, seg(1), 3);
        drive(A_MO, seg(2), 3);
        idle(2);
        RESET = 1'b1;
        idle(2);
        check_eq("midreset_digits_a", digs_a, 16'h0000);
        check_eq("midreset_digits_b", digs_b, 16'h0000);
        check_eq("midreset_locked", {lk_a, lk_b}, 2'b00);
        RESET = 1'b0;
        shown_a = 16'h0000;
        shown_b = 16'h0000;
        idle(1);
        b = cyc + 1;
        exp_at(0, EV_FV, 16'h0000, b + 9);
        exp_at(1, EV_FV, 16'h0000, b + 9);
        scan(seg(0), seg(0), seg(0), seg(0), 3, 0);
        idle(8);

        // 75:00: rejected only when the range check is built in.
        b = cyc + 1;
`ifdef SEG_SCAN_RANGE_CHECK_EN
        exp_at(0, EV_RNG, shown_a, b + 9);
        exp_at(1, EV_RNG, shown_b, b + 9);
`else
        exp_at(0, EV_FV, 16'h7500, b + 9);
        exp_at(1, EV_FV, 16'h7500, b + 9);
        shown_a = 16'h7500;
        shown_b = 16'h7500;
`endif
        scan(seg(7), seg(5), seg(0), seg(0), 3, 0);
        idle(8);
        check_eq("digits_a_after_7500", digs_a, shown_a);
        check_eq("digits_b_after_7500", digs_b, shown_b);

        // Early MT mid-frame restarts a frame.
        b = cyc + 1;
        exp_at(0, EV_SEQ, shown_a, b + 6);
        exp_at(1, EV_SEQ, shown_b, b + 6);
        exp_at(0, EV_FV, 16'h4831, b + 15);
        exp_at(1, EV_FV, 16'h4831, b + 15);
        drive(A_MT, seg(1), 3);
        drive(A_MO, seg(2), 3);
        scan(seg(4), seg(8), seg(3), seg(1), 3, 0);
        shown_a = 16'h4831;
        shown_b = 16'h4831;
        idle(8);
        check_eq("locked_a_restart", lk_a, 1'b1);
        check_eq("locked_b_restart", lk_b, 1'b1);

        // Two digits selected at once.
        b = cyc + 1;
        exp_at(0, EV_SEQ, shown_a, b);
        exp_at(1, EV_SEQ, shown_b, b);
        drive(4'b0011, seg(1), 3);
        idle(6);
        check_eq("locked_multi_low", {lk_a, lk_b}, 2'b00);
        check_eq("digits_a_multi_low", digs_a, 16'h4831);

        idle(12);
        check_eq("queue_a_drained", q_a.size(), 0);
        check_eq("queue_b_drained", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
